// File: rtl/calc_unit.sv
// Accumulator calculator: a 16-bit accumulator shown on the LEDs, updated while
// btnd is held by an 8-op ALU combining it with the switch operand.
module calc_unit (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned SHW = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_LT  = 3'b100,
    OP_LSL = 3'b101,
    OP_ASR = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  logic [DW-1:0]  acc;
  op_e            op_c;
  logic [AW-1:0]  a_c;
  logic [AW-1:0]  b_c;
  logic [SHW-1:0] shamt_c;
  logic           lt_c;
  logic [DW-1:0]  res_c;

  // Operands are sign-extended so that compare and arithmetic shift see true signs
  assign op_c    = op_e'({btnl, btnc, btnr});
  assign a_c     = {{(AW-DW){acc[DW-1]}}, acc};
  assign b_c     = {{(AW-DW){sw[DW-1]}}, sw};
  assign shamt_c = sw[SHW-1:0];
  assign lt_c    = $signed(a_c) < $signed(b_c);

  // ALU; only the low 16 bits of the 32-bit result are kept
  always_comb begin
    res_c = '0;
    case (op_c)
      OP_AND:  res_c = DW'(a_c & b_c);
      OP_OR:   res_c = DW'(a_c | b_c);
      OP_ADD:  res_c = DW'(a_c + b_c);
      OP_SUB:  res_c = DW'(a_c - b_c);
      OP_LT:   res_c = DW'(lt_c);
      OP_LSL:  res_c = DW'(a_c << shamt_c);
      OP_ASR:  res_c = DW'($signed(a_c) >>> shamt_c);
      OP_XOR:  res_c = DW'(a_c ^ b_c);
      default: res_c = '0;
    endcase
  end

  // Accumulator: async reset wins over the enter enable
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      acc <= '0;
    end else if (btnd) begin
      acc <= res_c;
    end
  end

  assign led = acc;

endmodule

// File: tb/tb_calc_unit.sv
// Directed self-checking bench for calc_unit: chained ops, hold, async reset,
// and wrap/shift boundaries against hand-computed values.
module tb_calc_unit;

  logic        clk;
  logic        btnu;
  logic        btnd;
  logic        btnl;
  logic        btnc;
  logic        btnr;
  logic [15:0] sw;
  logic [15:0] led;

  int checks;
  int errors;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  calc_unit dut (
    .clk  (clk),
    .btnu (btnu),
    .btnd (btnd),
    .btnl (btnl),
    .btnc (btnc),
    .btnr (btnr),
    .sw   (sw),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] op);
    {btnl, btnc, btnr} = op;
  endtask

  // Apply one enabled operation and check the accumulator after the edge
  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] operand,
                       input logic [15:0] exp);
    @(negedge clk);
    btnd = 1'b1;
    set_op(op);
    sw = operand;
    @(posedge clk);
    #1;
    check(tag, led, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    btnu = 1'b1;
    #1;
    check("reset_led", led, 16'h0000);
    @(negedge clk);
    btnu = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    checks = 0;
    errors = 0;
    btnu = 1'b0;
    btnd = 1'b0;
    sw   = '0;
    set_op(OP_AND);
    #1 btnu = 1'b1;
    #2;
    check("reset_init", led, 16'h0000);
    @(negedge clk);
    btnu = 1'b0;

    // Chained operations
    pulse_reset();
    do_op("add_354a", OP_ADD, 16'h354A, 16'h354A);
    do_op("sub_1234", OP_SUB, 16'h1234, 16'h2316);
    do_op("or_1001",  OP_OR,  16'h1001, 16'h3317);
    do_op("and_f0f0", OP_AND, 16'hF0F0, 16'h3010);
    do_op("xor_1fa2", OP_XOR, 16'h1FA2, 16'h2FB2);
    do_op("add_6aa2", OP_ADD, 16'h6AA2, 16'h9A54);
    do_op("lsl_4",    OP_LSL, 16'h0004, 16'hA540);
    do_op("asr_1",    OP_ASR, 16'h0001, 16'hD2A0);
    do_op("lt_neg",   OP_LT,  16'h46FF, 16'h0001);

    // Hold with btnd low
    held = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btnd = 1'b0;
      sw = 16'($urandom);
      set_op(3'($urandom));
      @(posedge clk);
      #1;
      check("hold", led, held);
    end

    // Async reset between edges with btnd high
    pulse_reset();
    do_op("add_9a54", OP_ADD, 16'h9A54, 16'h9A54);
    @(negedge clk);
    btnd = 1'b1;
    set_op(OP_ADD);
    sw = 16'h1111;
    #2 btnu = 1'b1;
    #1;
    check("async_rst_now", led, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_over_btnd", led, 16'h0000);
    @(negedge clk);
    btnu = 1'b0;
    btnd = 1'b0;

    // Wrap and shift boundaries
    do_op("add_7fff", OP_ADD, 16'h7FFF, 16'h7FFF);
    do_op("add_wrap", OP_ADD, 16'h0001, 16'h8000);
    do_op("asr_16",   OP_ASR, 16'h0010, 16'hFFFF);
    pulse_reset();
    do_op("sub_wrap", OP_SUB, 16'h0001, 16'hFFFF);
    do_op("and_8000", OP_AND, 16'h8000, 16'h8000);
    do_op("lsl_out",  OP_LSL, 16'h0001, 16'h0000);
    do_op("lt_equal", OP_LT,  16'h0000, 16'h0000);
    do_op("add_5",    OP_ADD, 16'h0005, 16'h0005);
    do_op("lt_pos",   OP_LT,  16'h0006, 16'h0001);

    @(negedge clk);
    btnd = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
